// File: rtl/cpu_ctrl_pkg.sv
// Shared state, opcode, bus-select and strobe definitions for the hardwired
// control sequencer.
package cpu_ctrl_pkg;

    localparam int unsigned OPC_W    = 5;
    localparam int unsigned REG_W    = 4;
    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned SEL_W    = 5;
    localparam int unsigned WAIT_W   = 4;
    localparam int unsigned IR_W     = 32;

    localparam int unsigned OPC_LSB = 27;
    localparam int unsigned RA_LSB  = 23;
    localparam int unsigned RB_LSB  = 19;
    localparam int unsigned RC_LSB  = 15;

    typedef enum logic [3:0] {
        ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
    } state_t;

    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_SHR  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_SHL  = 5'b00110;
    localparam logic [OPC_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OPC_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OPC_W-1:0] OP_AND  = 5'b01001;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b01010;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'b01011;
    localparam logic [OPC_W-1:0] OP_ANDI = 5'b01100;
    localparam logic [OPC_W-1:0] OP_ORI  = 5'b01101;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'b01110;
    localparam logic [OPC_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OPC_W-1:0] OP_NEG  = 5'b10000;
    localparam logic [OPC_W-1:0] OP_NOT  = 5'b10001;
    localparam logic [OPC_W-1:0] OP_MFHI = 5'b11000;
    localparam logic [OPC_W-1:0] OP_MFLO = 5'b11001;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

    // Codes 0-15 select R0-R15 directly.
    localparam logic [SEL_W-1:0] SEL_HI    = 5'd16;
    localparam logic [SEL_W-1:0] SEL_LO    = 5'd17;
    localparam logic [SEL_W-1:0] SEL_ZLO   = 5'd18;
    localparam logic [SEL_W-1:0] SEL_ZHI   = 5'd19;
    localparam logic [SEL_W-1:0] SEL_PC    = 5'd20;
    localparam logic [SEL_W-1:0] SEL_MDR   = 5'd21;
    localparam logic [SEL_W-1:0] SEL_IDLE  = 5'd22;
    localparam logic [SEL_W-1:0] SEL_C     = 5'd23;

    typedef enum logic [2:0] {
        CL_REG, CL_IMM, CL_MULDIV, CL_UNARY, CL_MFHI, CL_MFLO, CL_HALT, CL_ILLEGAL
    } op_class_t;

    typedef struct packed {
        logic [SEL_W-1:0]    bus_sel;
        logic [NUM_REGS-1:0] reg_in;
        logic                pc_in;
        logic                ir_in;
        logic                mar_in;
        logic                mdr_in;
        logic                y_in;
        logic                z_in;
        logic                hi_in;
        logic                lo_in;
        logic                inc_pc;
        logic                read;
        logic [OPC_W-1:0]    alu_op;
        logic                fault;
    } strobes_t;

    function automatic op_class_t op_class(input logic [OPC_W-1:0] op);
        op_class_t cls;
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR:   cls = CL_REG;
            OP_ADDI, OP_ANDI, OP_ORI:        cls = CL_IMM;
            OP_MUL, OP_DIV:                  cls = CL_MULDIV;
            OP_NEG, OP_NOT:                  cls = CL_UNARY;
            OP_MFHI:                         cls = CL_MFHI;
            OP_MFLO:                         cls = CL_MFLO;
            OP_HALT:                         cls = CL_HALT;
            default:                         cls = CL_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational map from sequencer step and IR fields to the datapath strobe
// bundle; exactly one bus source per step.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t            state,
    input  logic              t1_first,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [REG_W-1:0]  ra,
    input  logic [REG_W-1:0]  rb,
    input  logic [REG_W-1:0]  rc,
    output strobes_t          strobes
);

    op_class_t            cls;
    logic [SEL_W-1:0]     ra_sel;
    logic [SEL_W-1:0]     rb_sel;
    logic [SEL_W-1:0]     rc_sel;
    logic [NUM_REGS-1:0]  ra_onehot;

    assign cls       = op_class(opcode);
    assign ra_sel    = SEL_W'(ra);
    assign rb_sel    = SEL_W'(rb);
    assign rc_sel    = SEL_W'(rc);
    assign ra_onehot = NUM_REGS'(1) << ra;

    always_comb begin
        strobes         = '0;
        strobes.bus_sel = SEL_IDLE;
        unique case (state)
            ST_T0: begin
                strobes.bus_sel = SEL_PC;
                strobes.mar_in  = 1'b1;
                strobes.inc_pc  = 1'b1;
                strobes.z_in    = 1'b1;
            end
            ST_T1: begin
                strobes.bus_sel = SEL_ZLO;
                strobes.pc_in   = t1_first;
                strobes.read    = 1'b1;
                strobes.mdr_in  = 1'b1;
            end
            ST_T2: begin
                strobes.bus_sel = SEL_MDR;
                strobes.ir_in   = 1'b1;
            end
            ST_T3: begin
                unique case (cls)
                    CL_REG, CL_IMM: begin
                        strobes.bus_sel = rb_sel;
                        strobes.y_in    = 1'b1;
                    end
                    CL_MULDIV: begin
                        strobes.bus_sel = ra_sel;
                        strobes.y_in    = 1'b1;
                    end
                    CL_UNARY: begin
                        strobes.bus_sel = rb_sel;
                        strobes.alu_op  = opcode;
                        strobes.z_in    = 1'b1;
                    end
                    CL_MFHI: begin
                        strobes.bus_sel = SEL_HI;
                        strobes.reg_in  = ra_onehot;
                    end
                    CL_MFLO: begin
                        strobes.bus_sel = SEL_LO;
                        strobes.reg_in  = ra_onehot;
                    end
                    CL_HALT: ;
                    default: strobes.fault = 1'b1;
                endcase
            end
            ST_T4: begin
                unique case (cls)
                    CL_REG: begin
                        strobes.bus_sel = rc_sel;
                        strobes.alu_op  = opcode;
                        strobes.z_in    = 1'b1;
                    end
                    CL_IMM: begin
                        strobes.bus_sel = SEL_C;
                        strobes.alu_op  = opcode;
                        strobes.z_in    = 1'b1;
                    end
                    CL_MULDIV: begin
                        strobes.bus_sel = rb_sel;
                        strobes.alu_op  = opcode;
                        strobes.z_in    = 1'b1;
                    end
                    CL_UNARY: begin
                        strobes.bus_sel = SEL_ZLO;
                        strobes.reg_in  = ra_onehot;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                unique case (cls)
                    CL_REG, CL_IMM: begin
                        strobes.bus_sel = SEL_ZLO;
                        strobes.reg_in  = ra_onehot;
                    end
                    CL_MULDIV: begin
                        strobes.bus_sel = SEL_ZLO;
                        strobes.lo_in   = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                if (cls == CL_MULDIV) begin
                    strobes.bus_sel = SEL_ZHI;
                    strobes.hi_in   = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_control_sequencer.sv
// Hardwired fetch/execute sequencer: owns the step register, the memory wait
// counter and step transitions; strobes are decoded by ctrl_decode.
module cpu_control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [IR_W-1:0]    ir,
    input  logic               mem_ready,
    output logic [SEL_W-1:0]   bus_sel,
    output logic [NUM_REGS-1:0] reg_in,
    output logic               pc_in,
    output logic               ir_in,
    output logic               mar_in,
    output logic               mdr_in,
    output logic               y_in,
    output logic               z_in,
    output logic               hi_in,
    output logic               lo_in,
    output logic               inc_pc,
    output logic               read,
    output logic [OPC_W-1:0]   alu_op,
    output logic               busy,
    output logic               halted,
    output logic               fault
);

    // Last T1 wait slot: ready there still wins, otherwise the fetch aborts.
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MEM_TIMEOUT - 1);

    state_t             state;
    state_t             state_nxt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [WAIT_W-1:0]  wait_cnt_nxt;
    logic               timeout_q;
    logic               timeout_nxt;
    logic [OPC_W-1:0]   opcode;
    op_class_t          cls;
    strobes_t           strobes;
    logic               unused_ir_low;

    assign opcode        = ir[OPC_LSB +: OPC_W];
    assign cls           = op_class(opcode);
    assign unused_ir_low = ^ir[RC_LSB-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    // Counter only advances while stalled in T1, so it reads zero on T1 entry.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = '0;
        timeout_nxt  = 1'b0;
        unique case (state)
            ST_IDLE: if (run) state_nxt = ST_T0;
            ST_T0:   state_nxt = ST_T1;
            ST_T1: begin
                if (mem_ready) begin
                    state_nxt = ST_T2;
                end else if (wait_cnt == LAST_WAIT) begin
                    state_nxt   = ST_IDLE;
                    timeout_nxt = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            ST_T2:   state_nxt = ST_T3;
            ST_T3: begin
                unique case (cls)
                    CL_REG, CL_IMM, CL_MULDIV, CL_UNARY: state_nxt = ST_T4;
                    CL_HALT:                             state_nxt = ST_HALT;
                    default:                             state_nxt = ST_IDLE;
                endcase
            end
            ST_T4: begin
                unique case (cls)
                    CL_REG, CL_IMM, CL_MULDIV: state_nxt = ST_T5;
                    default:                   state_nxt = ST_IDLE;
                endcase
            end
            ST_T5:   state_nxt = (cls == CL_MULDIV) ? ST_T6 : ST_IDLE;
            ST_T6:   state_nxt = ST_IDLE;
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_IDLE;
        endcase
    end

    ctrl_decode u_decode (
        .state    (state),
        .t1_first (wait_cnt == '0),
        .opcode   (opcode),
        .ra       (ir[RA_LSB +: REG_W]),
        .rb       (ir[RB_LSB +: REG_W]),
        .rc       (ir[RC_LSB +: REG_W]),
        .strobes  (strobes)
    );

    assign bus_sel = strobes.bus_sel;
    assign reg_in  = strobes.reg_in;
    assign pc_in   = strobes.pc_in;
    assign ir_in   = strobes.ir_in;
    assign mar_in  = strobes.mar_in;
    assign mdr_in  = strobes.mdr_in;
    assign y_in    = strobes.y_in;
    assign z_in    = strobes.z_in;
    assign hi_in   = strobes.hi_in;
    assign lo_in   = strobes.lo_in;
    assign inc_pc  = strobes.inc_pc;
    assign read    = strobes.read;
    assign alu_op  = strobes.alu_op;
    assign fault   = strobes.fault | timeout_q;
    assign busy    = (state != ST_IDLE) && (state != ST_HALT);
    assign halted  = (state == ST_HALT);

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Self-checking bench: per-cycle output records predicted from the
// instruction-step table and compared against the sequencer.
module tb_cpu_control_sequencer;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [31:0] ir;
    logic        mem_ready;
    logic [4:0]  bus_sel;
    logic [15:0] reg_in;
    logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, inc_pc, read;
    logic [4:0]  alu_op;
    logic        busy, halted, fault;

    cpu_control_sequencer #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .run(run), .ir(ir), .mem_ready(mem_ready),
        .bus_sel(bus_sel), .reg_in(reg_in), .pc_in(pc_in), .ir_in(ir_in),
        .mar_in(mar_in), .mdr_in(mdr_in), .y_in(y_in), .z_in(z_in),
        .hi_in(hi_in), .lo_in(lo_in), .inc_pc(inc_pc), .read(read),
        .alu_op(alu_op), .busy(busy), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  bus_sel;
        logic [15:0] reg_in;
        logic [9:0]  strb;
        logic [4:0]  alu_op;
        logic        busy;
        logic        halted;
        logic        fault;
    } obs_t;

    // Strobe order: pc_in ir_in mar_in mdr_in y_in z_in hi_in lo_in inc_pc read
    localparam logic [9:0] S_NONE = 10'b00_0000_0000;
    localparam logic [9:0] S_PC   = 10'b10_0000_0000;
    localparam logic [9:0] S_IR   = 10'b01_0000_0000;
    localparam logic [9:0] S_MAR  = 10'b00_1000_0000;
    localparam logic [9:0] S_MDR  = 10'b00_0100_0000;
    localparam logic [9:0] S_Y    = 10'b00_0010_0000;
    localparam logic [9:0] S_Z    = 10'b00_0001_0000;
    localparam logic [9:0] S_HI   = 10'b00_0000_1000;
    localparam logic [9:0] S_LO   = 10'b00_0000_0100;
    localparam logic [9:0] S_INC  = 10'b00_0000_0010;
    localparam logic [9:0] S_RD   = 10'b00_0000_0001;

    int   total = 0;
    int   bad   = 0;
    obs_t exp_q[$];
    int   fetch_len;
    int   t1_len;

    function automatic obs_t rec(input int bus, input logic [15:0] rin, input logic [9:0] strb,
                                 input int alu, input logic bsy, input logic hlt, input logic flt);
        rec = {5'(bus), rin, strb, 5'(alu), bsy, hlt, flt};
    endfunction

    function automatic logic [15:0] onehot(input int r);
        logic [15:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    function automatic obs_t observe();
        observe = {bus_sel, reg_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in,
                   hi_in, lo_in, inc_pc, read, alu_op, busy, halted, fault};
    endfunction

    task automatic check(input string tag, input obs_t want);
        obs_t got;
        got = observe();
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    // Expected record per cycle, from T0 through the following IDLE (or HALT).
    task automatic build_expect(input int op, input int ra, input int rb, input int rc,
                                input int w, input int n_halt);
        exp_q.delete();
        exp_q.push_back(rec(20, '0, S_MAR | S_INC | S_Z, 0, 1'b1, 1'b0, 1'b0));
        t1_len = (w < TIMEOUT) ? w + 1 : TIMEOUT;
        for (int i = 0; i < t1_len; i++)
            exp_q.push_back(rec(18, '0, S_RD | S_MDR | ((i == 0) ? S_PC : S_NONE), 0, 1'b1, 1'b0, 1'b0));
        if (w >= TIMEOUT) begin
            fetch_len = exp_q.size();
            exp_q.push_back(rec(22, '0, S_NONE, 0, 1'b0, 1'b0, 1'b1));
            return;
        end
        exp_q.push_back(rec(21, '0, S_IR, 0, 1'b1, 1'b0, 1'b0));
        fetch_len = exp_q.size();
        if (op >= 3 && op <= 10) begin
            exp_q.push_back(rec(rb, '0, S_Y, 0, 1'b1, 1'b0, 1'b0));
            exp_q.push_back(rec(rc, '0, S_Z, op, 1'b1, 1'b0, 1'b0));
            exp_q.push_back(rec(18, onehot(ra), S_NONE, 0, 1'b1, 1'b0, 1'b0));
        end else if (op >= 11 && op <= 13) begin
            exp_q.push_back(rec(rb, '0, S_Y, 0, 1'b1, 1'b0, 1'b0));
            exp_q.push_back(rec(23, '0, S_Z, op, 1'b1, 1'b0, 1'b0));
            exp_q.push_back(rec(18, onehot(ra), S_NONE, 0, 1'b1, 1'b0, 1'b0));
        end else if (op == 14 || op == 15) begin
            exp_q.push_back(rec(ra, '0, S_Y, 0, 1'b1, 1'b0, 1'b0));
            exp_q.push_back(rec(rb, '0, S_Z, op, 1'b1, 1'b0, 1'b0));
            exp_q.push_back(rec(18, '0, S_LO, 0, 1'b1, 1'b0, 1'b0));
            exp_q.push_back(rec(19, '0, S_HI, 0, 1'b1, 1'b0, 1'b0));
        end else if (op == 16 || op == 17) begin
            exp_q.push_back(rec(rb, '0, S_Z, op, 1'b1, 1'b0, 1'b0));
            exp_q.push_back(rec(18, onehot(ra), S_NONE, 0, 1'b1, 1'b0, 1'b0));
        end else if (op == 24 || op == 25) begin
            exp_q.push_back(rec((op == 24) ? 16 : 17, onehot(ra), S_NONE, 0, 1'b1, 1'b0, 1'b0));
        end else if (op == 27) begin
            exp_q.push_back(rec(22, '0, S_NONE, 0, 1'b1, 1'b0, 1'b0));
            for (int i = 0; i < n_halt; i++)
                exp_q.push_back(rec(22, '0, S_NONE, 0, 1'b0, 1'b1, 1'b0));
            return;
        end else begin
            exp_q.push_back(rec(22, '0, S_NONE, 0, 1'b1, 1'b0, 1'b1));
        end
        exp_q.push_back(rec(22, '0, S_NONE, 0, 1'b0, 1'b0, 1'b0));
    endtask

    // Entered at an IDLE sample point; w = T1 cycles with mem_ready low before it rises.
    task automatic run_instr(input string tag, input logic [4:0] op, input logic [3:0] ra,
                             input logic [3:0] rb, input logic [3:0] rc, input int w,
                             input int abort_at);
        logic [31:0] instr;
        int          n;
        instr = {op, ra, rb, rc, 15'($urandom)};
        build_expect(int'(op), int'(ra), int'(rb), int'(rc), w, 3);
        n = exp_q.size();
        if (abort_at >= n || (op == 5'b11011 && abort_at < 0))
            abort_at = n - 1;
        run = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            ir        = (k < fetch_len) ? $urandom : instr;
            mem_ready = (k >= 1 && k <= t1_len) ? (k - 1 == w) : 1'($urandom);
            run       = (k == n - 1 && !exp_q[k].busy && !exp_q[k].halted) ? 1'b0 : 1'b1;
            #1;
            check($sformatf("%s k=%0d", tag, k), exp_q[k]);
            if (k == abort_at) begin
                reset = 1'b1;
                run   = 1'b1;
                @(posedge clk);
                #1;
                reset     = 1'b0;
                mem_ready = 1'($urandom);
                #1;
                check({tag, " after-reset"}, rec(22, '0, S_NONE, 0, 1'b0, 1'b0, 1'b0));
                return;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        run       = 1'b1;
        mem_ready = 1'b1;
        ir        = $urandom;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            ir = $urandom;
            #1;
            check($sformatf("reset hold %0d", i), rec(22, '0, S_NONE, 0, 1'b0, 1'b0, 1'b0));
        end
        reset = 1'b0;
        run   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #2;
            check($sformatf("idle no-run %0d", i), rec(22, '0, S_NONE, 0, 1'b0, 1'b0, 1'b0));
        end

        run_instr("add r5,r2,r3",   5'b00011, 4'd5, 4'd2, 4'd3, 0, -1);
        run_instr("add wait3",      5'b00011, 4'd1, 4'd9, 4'd12, 3, -1);
        run_instr("timeout",        5'b00100, 4'd2, 4'd3, 4'd4, TIMEOUT, -1);
        run_instr("ready at limit", 5'b01010, 4'd15, 4'd0, 4'd7, TIMEOUT - 1, -1);
        run_instr("mul r6,r7",      5'b01110, 4'd6, 4'd7, 4'd1, 0, -1);
        run_instr("illegal",        5'b11111, 4'd3, 4'd4, 4'd5, 0, -1);
        run_instr("halt",           5'b11011, 4'd0, 4'd0, 4'd0, 1, -1);
        run_instr("addi abort T4",  5'b01011, 4'd8, 4'd1, 4'd0, 0, 4);
        run_instr("sub after rst",  5'b00100, 4'd0, 4'd14, 4'd13, 0, -1);
        run_instr("neg",            5'b10000, 4'd11, 4'd10, 4'd0, 2, -1);
        run_instr("mfhi",           5'b11000, 4'd4, 4'd0, 4'd0, 0, -1);
        run_instr("mflo",           5'b11001, 4'd9, 4'd0, 4'd0, 1, -1);
        run_instr("div",            5'b01111, 4'd12, 4'd3, 4'd0, 0, -1);

        for (int t = 0; t < 60; t++) begin
            logic [4:0] op;
            int         w;
            int         ab;
            int         sel;
            op  = 5'($urandom);
            sel = int'($urandom_range(0, 9));
            w   = (sel == 0) ? TIMEOUT - 1 : (sel == 1) ? TIMEOUT : int'($urandom_range(0, 3));
            ab  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 5)) : -1;
            run_instr($sformatf("rand%0d op=%0d", t, op), op, 4'($urandom), 4'($urandom),
                      4'($urandom), w, ab);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_control_sequencer.md
# cpu_control_sequencer

Hardwired control sequencer for the 32-bit datapath: it walks each instruction through fetch (T0–T2) and execute (T3–T6) phases. It drives the 5-bit bus multiplexer select and every register-enable and ALU-control strobe, and handshakes with memory during the instruction read. It sits between the instruction register and the bus/register file, and it is the only master of the bus select.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 15: maximum cycles waited in T1 for `mem_ready` before a fault.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `run` in 1: level; while high, the sequencer starts a new fetch whenever it is in IDLE.
- `ir` in 32: IR register contents. `[31:27]` = opcode, `[26:23]` = ra, `[22:19]` = rb, `[18:15]` = rc.
- `mem_ready` in 1: memory read data is valid on the MDR input this cycle.
- `bus_sel` out 5: bus mux select.
- `reg_in` out 16: one-hot general register write enable.
- `pc_in`, `ir_in`, `mar_in`, `mdr_in`, `y_in`, `z_in`, `hi_in`, `lo_in`, `inc_pc`, `read` out 1 each: datapath strobes.
- `alu_op` out 5: ALU function, equal to the opcode during the ALU step, otherwise 0.
- `busy` out 1: high in any state except IDLE and HALT.
- `halted` out 1: high in HALT.
- `fault` out 1: one-cycle pulse on an illegal opcode or a memory timeout.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT.
- Outputs are Moore-style: decoded from the state register and `ir` only.
- Bus select codes, fixed in the package:
  - R0–R15 = 0–15
  - HI = 16, LO = 17, Zlow = 18, Zhigh = 19, PC = 20, MDR = 21
  - IDLE code = 22 (the bus carries zero)
  - C sign-extended = 23
- A register-source step uses `bus_sel = {1'b0, reg}`. A register write uses `reg_in = 1 << reg`.
- IDLE: all strobes 0, `bus_sel` = 22. Go to T0 if `run`.
- T0: `bus_sel` = PC, `mar_in`, `inc_pc`, `z_in`. Go to T1.
- T1: `bus_sel` = Zlow, `pc_in` in the first T1 cycle only; `read` and `mdr_in` in every T1 cycle.
  - Stay in T1 until `mem_ready`=1, then go to T2.
  - Wait counter (4 bits) clears on entry. If it reaches `MEM_TIMEOUT` with no ready, pulse `fault` and go to IDLE.
- T2: `bus_sel` = MDR, `ir_in`. Go to T3.
- T3 onward decodes the opcode:
  - Reg ALU (00011–01010: add, sub, shr, shl, ror, rol, and, or):
    - T3: rb out, `y_in`.
    - T4: rc out, `alu_op`, `z_in`.
    - T5: Zlow out, `reg_in[ra]`. Then IDLE.
  - Immediate (01011–01101: addi, andi, ori):
    - T3: rb out, `y_in`.
    - T4: C out (23), `alu_op`, `z_in`.
    - T5: Zlow out, `reg_in[ra]`. Then IDLE.
  - Mul/div (01110, 01111):
    - T3: ra out, `y_in`.
    - T4: rb out, `alu_op`, `z_in`.
    - T5: Zlow out, `lo_in`.
    - T6: Zhigh out, `hi_in`. Then IDLE.
  - Unary (10000 neg, 10001 not):
    - T3: rb out, `alu_op`, `z_in`.
    - T4: Zlow out, `reg_in[ra]`. Then IDLE.
  - mfhi (11000), mflo (11001):
    - T3: HI (16) or LO (17) out, `reg_in[ra]`. Then IDLE.
  - halt (11011): T3 to HALT. HALT is left only by `reset`.
  - Any other opcode: in T3, all strobes 0 and `fault`=1, then IDLE.
- Exactly one bus source is selected per cycle. No step asserts two register-file enables.

## Timing
- Reset: state = IDLE, wait counter = 0. Every output reads 0, except `bus_sel` = 22.
- Reset asserted mid-instruction wins over every transition. Strobes are 0 from the first cycle after the reset edge.
- From `run` high in IDLE, T0 is the next cycle.
- Fetch takes 3 cycles plus the memory wait cycles. Execute takes 1–4 cycles.
- A reg ALU instruction with zero wait takes 6 cycles T0→T5. IDLE follows, and `busy` drops there.
- `run` sampled high in IDLE starts the next fetch. Back-to-back instructions therefore cost one IDLE cycle.
- `mem_ready` is sampled every T1 cycle, including the first.
- `mem_ready` arriving in the same cycle the counter hits `MEM_TIMEOUT` counts as ready: no fault.
- `ir` is valid from T3 onward. T0–T2 outputs must not depend on `ir`.

## Structure
- `cpu_ctrl_pkg` holds:
  - the state enum;
  - opcode constants;
  - bus select code constants (0–23);
  - IR field positions.
- Natural sub-module: `ctrl_decode`, a combinational mapping (state, ir) → strobe bundle.
- The top level keeps the state register, the wait counter and the transition logic.

## Test plan
- add R5,R2,R3, `mem_ready` tied 1:
  - `bus_sel` sequence 20, 18, 21, 2, 3, 18.
  - `reg_in` = 16'h0020 in T5 only.
  - `alu_op` = 00011 in T4.
- `mem_ready` delayed 3 cycles: T1 held 4 cycles. `read` high throughout, `pc_in` only in the first T1 cycle, no `fault`.
- `mem_ready` never asserted: `fault` pulses once after 15 T1 cycles, state returns to IDLE, no `ir_in` seen.
- mul R6,R7: T5 has `bus_sel` 18 with `lo_in`; T6 has `bus_sel` 19 with `hi_in`; no `reg_in` asserted.
- Illegal opcode 11111: `fault` in T3, zero strobes, IDLE next. halt 11011: HALT is held with `run`=1 until `reset`.
- `reset` asserted in T4 of an addi: IDLE and all strobes 0 on the next cycle. A new fetch starts one cycle after `reset` deasserts with `run`=1.
